// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: sequencer that drives a small single-port RAM (DEPTH = 2**ADDR_W
// words of DATA_W bits). The RAM works as a circular FIFO buffer. Clients use a
// req/ack handshake to write into it or read out of it.
//
// Handshake: wr_req/rd_req are levels that the client holds until the matching
// one-cycle ack pulse. A request is sampled only in IDLE. rd_valid pulses
// for one cycle when rd_data has been updated.
//
// Ports:
//   clk, clr            clock (rising edge), synchronous active-high reset
//   wr_req, wr_data     client write request / data;  wr_ack  write accepted
//   rd_req              client read request;          rd_ack  read accepted
//   rd_data, rd_valid   registered read result and its update pulse
//   busy                FSM not in IDLE
//   full, empty, count  occupancy, derived from the registered count
//   ram_rw, ram_addr, ram_clr, ram_wdata, ram_rdata   RAM-side interface
//   err_ovf, err_udf    sticky error flags. These are real registers only when
//                       RAM_SEQ_CTRL_ERR_EN is defined; otherwise they are tied to 0.
module ram_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_clr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state, state_nx;
  logic                accept_wr, accept_rd;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   wdata_q;

  assign count     = count_q;
  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state != IDLE);
  assign ram_clr   = clr;
  // Gating with clr makes sure no RAM write happens on a reset edge, even mid-WRITE.
  assign ram_rw    = (state == WRITE) & ~clr;
  assign ram_addr  = (state == WRITE) ? wr_ptr : rd_ptr;
  assign ram_wdata = wdata_q;

  // Next-state logic and arbitration. A read wins over a write when both are eligible.
  // The losing request stays pending and is arbitrated again when the FSM returns to IDLE.
  always_comb begin
    state_nx  = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && !empty) begin
          accept_rd = 1'b1;
          state_nx  = READ;
        end else if (wr_req && !full) begin
          accept_wr = 1'b1;
          state_nx  = WRITE;
        end
      end
      WRITE:   state_nx = IDLE;
      READ:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      wdata_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
    end else begin
      // Each ack is set by the accepting edge, so it is high during the WRITE or READ cycle.
      wr_ack   <= accept_wr;
      rd_ack   <= accept_rd;
      rd_valid <= (state == READ);
      if (accept_wr) wdata_q <= wr_data;
      if (state == WRITE) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        count_q <= count_q + CNT_ONE;
      end
      if (state == READ) begin
        rd_data <= ram_rdata;
        rd_ptr  <= rd_ptr + PTR_ONE;
        count_q <= count_q - CNT_ONE;
      end
    end
  end

`ifdef RAM_SEQ_CTRL_ERR_EN
  logic ovf_q, udf_q;

  // The flags are sticky: once set, they stay set until clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (state == IDLE && wr_req && full)  ovf_q <= 1'b1;
      if (state == IDLE && rd_req && empty) udf_q <= 1'b1;
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Sequencer directly upstream of the 2-word x 8-bit RAM. It drives that RAM's rw, addr, clr and data_in, and receives its data_out.
- Accepts write/read requests from a client with a req/ack handshake and uses the RAM as a circular FIFO buffer.
- Tracks occupancy and reports full/empty.

Parameters:
- DATA_W, 8, data width; matches the RAM word.
- ADDR_W, 1, RAM address width; DEPTH = 2**ADDR_W (2 words).

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- wr_req  in  1  client write request; level, held until wr_ack.
- wr_data  in  DATA_W  write data, valid while wr_req=1.
- wr_ack  out  1  one-cycle pulse: write accepted.
- rd_req  in  1  client read request; level, held until rd_ack.
- rd_ack  out  1  one-cycle pulse: read accepted.
- rd_data  out  DATA_W  registered read result.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- busy  out  1  1 when state != IDLE.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  words stored, 0..DEPTH.
- ram_rw  out  1  to RAM rw; 1 = write, 0 = read.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_clr  out  1  to RAM clr; equals clr (combinational).
- ram_wdata  out  DATA_W  to RAM data_in.
- ram_rdata  in  DATA_W  from RAM data_out; valid in the same cycle as ram_rw=0 with a stable ram_addr.
- err_ovf  out  1  sticky overflow flag (optional feature).
- err_udf  out  1  sticky underflow flag (optional feature).

Behaviour:
- Reset (clr=1 at a rising edge):
  - state=IDLE; wr_ptr=rd_ptr=0; count=0.
  - rd_data=0; rd_valid=wr_ack=rd_ack=0; err flags=0.
  - clr overrides every other input.
  - ram_rw is gated: ram_rw = (state==WRITE) & ~clr, so no RAM write occurs on an edge where clr=1. This applies even mid-WRITE; the aborted write is lost.
- FSM states: IDLE, WRITE, READ.
- IDLE, arbitration per cycle:
  - rd_req & ~empty -> accept read: rd_ack=1 next cycle, go READ.
  - else wr_req & ~full -> accept write: latch wr_data into ram_wdata register, wr_ack=1 next cycle, go WRITE.
  - Read has priority when both are eligible. The losing request stays pending and is re-arbitrated on the return to IDLE.
  - wr_req while full, or rd_req while empty: not acked, stays in IDLE.
- WRITE (1 cycle): ram_rw=1, ram_addr=wr_ptr.
  - At the edge: wr_ptr=(wr_ptr+1) mod DEPTH, count+1, go IDLE.
- READ (1 cycle): ram_rw=0, ram_addr=rd_ptr.
  - At the edge: rd_data<=ram_rdata, rd_valid=1 for the next cycle.
  - rd_ptr=(rd_ptr+1) mod DEPTH, count-1, go IDLE.
- IDLE outputs: ram_rw=0, ram_addr=rd_ptr.
- Latency:
  - Write: request sampled in cycle N; ack and RAM write in cycle N+1; count visible in N+2.
  - Read: request sampled in N; ack and RAM read in N+1; rd_data/rd_valid in N+2.
- Throughput: at most 1 operation per 2 cycles. busy=1 in WRITE and READ; requests are not sampled while busy.
- Pointers wrap modulo DEPTH with no extra state.
- count never exceeds DEPTH and never goes below 0; guaranteed by the IDLE eligibility checks.
- full/empty/count are combinational from registered count.
- Simultaneous wr_req and rd_req when full: the read runs first; the write is accepted on the next IDLE.
- Simultaneous requests when empty: only the write is eligible.

Optional Feature:
- Macro RAM_SEQ_CTRL_ERR_EN.
- Defined:
  - err_ovf is set when wr_req=1 while IDLE and full.
  - err_udf is set when rd_req=1 while IDLE and empty.
  - Both are sticky until clr.
- Undefined: err_ovf and err_udf tied to 0; no flag registers.

Test Plan:
- After clr, check the idle state:
  - count=0, empty=1, full=0, rd_valid=0, ram_rw=0.
  - ram_clr follows clr.
- Write 0xA5, then write 0x3C:
  - wr_ack one cycle after each request.
  - ram_rw=1 with ram_addr=0 then ram_addr=1.
  - Final state: count=2, full=1.
- From full, issue two reads:
  - rd_data=0xA5, then 0x3C, each with a 1-cycle rd_valid two cycles after its request.
  - empty=1 at the end.
- Wrap-around: write 0x11, 0x22, read, write 0x33, read, read:
  - Read results in order: 0x11, 0x22, 0x33.
  - The third write lands at ram_addr=0.
- Overflow/underflow:
  - rd_req while empty -> no rd_ack for 5 cycles.
  - wr_req while full -> no wr_ack.
  - Simultaneous wr_req+rd_req while full -> read acked first, write acked on the next IDLE.
  - With RAM_SEQ_CTRL_ERR_EN: err_udf=1 and err_ovf=1, cleared only by clr.
- clr asserted during the WRITE cycle of 0x77:
  - ram_rw=0 on that edge; count=0 afterwards.
  - A subsequent read is not acked (empty).
